// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, FSM states, request address fields and mode-register builder
// shared by sdram_ctrl and its refresh timer.
package sdram_pkg;
   typedef enum logic [3:0] {
      CMD_MRS = 4'b0000,
      CMD_REF = 4'b0001,
      CMD_PRE = 4'b0010,
      CMD_ACT = 4'b0011,
      CMD_WR  = 4'b0100,
      CMD_RD  = 4'b0101,
      CMD_NOP = 4'b0111
   } cmd_t;
   typedef enum logic [3:0] {
      S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
      S_IDLE, S_REFRESH, S_ACTIVATE, S_RW, S_WAIT
   } state_t;
   localparam int ADDR_BANK_HI = 23;
   localparam int ADDR_BANK_LO = 22;
   localparam int ADDR_ROW_HI  = 21;
   localparam int ADDR_ROW_LO  = 9;
   localparam int ADDR_COL_HI  = 8;
   localparam int ADDR_COL_LO  = 0;
   // single-location writes, sequential burst type, burst length 1
   function automatic logic [12:0] mode_reg(input logic [2:0] cl);
      return {3'b000, 1'b1, 2'b00, cl, 1'b0, 3'b000};
   endfunction
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval counter; raises pending every T_REFI cycles
// while en is high and drops it on ack. A repeated expiry while pending is absorbed.
module sdram_refresh_timer #(
   parameter int T_REFI = 380
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic ack,
   output logic pending
);
   localparam int W = $clog2(T_REFI + 1);
   logic [W-1:0] cnt;
   logic         expire;
   assign expire = en && cnt == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt     <= W'(T_REFI - 1);
         pending <= 1'b0;
      end else begin
         cnt     <= !en ? cnt : (expire ? W'(T_REFI - 1) : cnt - 1'b1);
         pending <= expire || (pending && !ack);
      end
endmodule

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-requester MT48LC16M16A2 controller (init, auto-refresh, ACT + RD/WR with auto-precharge).
// Define SDRAM_RDATA_REG_EN to add an input register on sdram_d; read response moves one cycle later.
module sdram_ctrl
   import sdram_pkg::*;
#(
   parameter int T_INIT      = 5000,
   parameter int T_RP        = 1,
   parameter int T_RCD       = 1,
   parameter int T_RFC       = 4,
   parameter int T_WR        = 2,
   parameter int T_MRD       = 2,
   parameter int T_REFI      = 380,
   parameter int CAS_LATENCY = 2
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_wmask,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        init_done,
   output logic        sdram_cke,
   output logic        sdram_csn,
   output logic        sdram_rasn,
   output logic        sdram_casn,
   output logic        sdram_wen,
   output logic [12:0] sdram_a,
   output logic [1:0]  sdram_ba,
   output logic [1:0]  sdram_dqm,
   inout  wire  [15:0] sdram_d
);
`ifdef SDRAM_RDATA_REG_EN
   localparam int RD_EXTRA = 1;
`else
   localparam int RD_EXTRA = 0;
`endif
   localparam int RD_WAIT = ((CAS_LATENCY + 1 > T_RP) ? CAS_LATENCY + 1 : T_RP) + RD_EXTRA;
   localparam int WR_WAIT = T_WR + T_RP;
   localparam int CW      = $clog2((T_INIT > T_REFI ? T_INIT : T_REFI) + 1);
   localparam int PW      = CAS_LATENCY + RD_EXTRA + 1;
   state_t        state;
   cmd_t          cmd;
   logic [CW-1:0] cnt;
   logic [PW-1:0] rd_pipe;
   logic [23:0]   addr_q;
   logic [15:0]   wdata_q, dq_out, dq_in;
   logic [1:0]    wmask_q;
   logic          we_q, dq_oe, done, pending, ack, rd_issue;
   assign {sdram_csn, sdram_rasn, sdram_casn, sdram_wen} = cmd;
   assign sdram_d   = dq_oe ? dq_out : 'z;
   assign done      = cnt == '0;
   assign req_ready = state == S_IDLE && init_done && !pending;
   assign ack       = state == S_IDLE && pending;
   assign rd_issue  = state == S_ACTIVATE && done && !we_q;
`ifdef SDRAM_RDATA_REG_EN
   logic [15:0] dq_q;
   always_ff @(posedge clk_sys or posedge rst)
      if (rst) dq_q <= '0;
      else dq_q <= sdram_d;
   assign dq_in = dq_q;
`else
   assign dq_in = sdram_d;
`endif
   sdram_refresh_timer #(.T_REFI(T_REFI)) u_refresh (
      .clk(clk_sys), .rst(rst), .en(init_done), .ack(ack), .pending(pending)
   );
   // rd_pipe[k] marks the k-th cycle after RD; the top bit is the capture cycle
   always_ff @(posedge clk_sys or posedge rst)
      if (rst) begin
         state     <= S_INIT_WAIT;
         cnt       <= CW'(T_INIT);
         cmd       <= CMD_NOP;
         sdram_cke <= 1'b0;
         sdram_a   <= '0;
         sdram_ba  <= '0;
         sdram_dqm <= 2'b11;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         init_done <= 1'b0;
         rd_pipe   <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wmask_q   <= '0;
      end else begin
         sdram_cke <= 1'b1;
         cmd       <= CMD_NOP;
         dq_oe     <= 1'b0;
         cnt       <= done ? cnt : cnt - 1'b1;
         rd_pipe   <= {rd_pipe[PW-2:0], rd_issue};
         rsp_valid <= rd_pipe[PW-1];
         if (rd_pipe[PW-1]) rsp_rdata <= dq_in;
         case (state)
            S_INIT_WAIT: if (done) begin
               state   <= S_INIT_PRE;
               cmd     <= CMD_PRE;
               sdram_a <= 13'h0400;
               cnt     <= CW'(T_RP - 1);
            end
            S_INIT_PRE: if (done) begin
               state <= S_INIT_REF1;
               cmd   <= CMD_REF;
               cnt   <= CW'(T_RFC - 1);
            end
            S_INIT_REF1: if (done) begin
               state <= S_INIT_REF2;
               cmd   <= CMD_REF;
               cnt   <= CW'(T_RFC - 1);
            end
            S_INIT_REF2: if (done) begin
               state    <= S_INIT_MRS;
               cmd      <= CMD_MRS;
               sdram_a  <= mode_reg(3'(CAS_LATENCY));
               sdram_ba <= 2'b00;
               cnt      <= CW'(T_MRD - 1);
            end
            S_INIT_MRS: if (done) begin
               state     <= S_IDLE;
               init_done <= 1'b1;
            end
            S_IDLE: if (pending) begin
               state <= S_REFRESH;
               cmd   <= CMD_REF;
               cnt   <= CW'(T_RFC - 1);
            end else if (req_valid && req_ready) begin
               state    <= S_ACTIVATE;
               cmd      <= CMD_ACT;
               sdram_ba <= req_addr[ADDR_BANK_HI:ADDR_BANK_LO];
               sdram_a  <= req_addr[ADDR_ROW_HI:ADDR_ROW_LO];
               addr_q   <= req_addr;
               we_q     <= req_we;
               wdata_q  <= req_wdata;
               wmask_q  <= req_wmask;
               cnt      <= CW'(T_RCD - 1);
            end
            S_REFRESH: if (done) state <= S_IDLE;
            S_ACTIVATE: if (done) begin
               state     <= S_RW;
               cmd       <= we_q ? CMD_WR : CMD_RD;
               sdram_a   <= {3'b001, 1'b0, addr_q[ADDR_COL_HI:ADDR_COL_LO]};
               sdram_dqm <= we_q ? ~wmask_q : 2'b00;
               dq_oe     <= we_q;
               dq_out    <= wdata_q;
            end
            S_RW: begin
               state <= S_WAIT;
               cnt   <= we_q ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);
            end
            S_WAIT: if (done) state <= S_IDLE;
            default: state <= S_INIT_WAIT;
         endcase
      end
endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: random word reads/writes against a behavioural SDRAM pin model and a word-level
// reference memory; read responses are checked by a scoreboard monitor for data and latency.
module tb_sdram_ctrl;
   localparam int T_INIT = 5000, T_RP = 1, T_RCD = 1, T_RFC = 4, T_WR = 2, T_MRD = 2, T_REFI = 380, CL = 2;
`ifdef SDRAM_RDATA_REG_EN
   localparam int LAT = CL + 2;
`else
   localparam int LAT = CL + 1;
`endif
   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

   logic        clk_sys = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
   logic [23:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_wmask = '0;
   logic        req_ready, rsp_valid, init_done;
   logic        sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen;
   logic [15:0] rsp_rdata;
   logic [12:0] sdram_a;
   logic [1:0]  sdram_ba, sdram_dqm;
   wire  [15:0] sdram_d;
   logic        m_oe = 1'b0;
   logic [15:0] m_d = '0;
   assign sdram_d = m_oe ? m_d : 'z;

   int vectors = 0, miscompares = 0, cyc = 0;
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   sdram_ctrl dut (
      .clk_sys(clk_sys), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .init_done(init_done), .sdram_cke(sdram_cke), .sdram_csn(sdram_csn),
      .sdram_rasn(sdram_rasn), .sdram_casn(sdram_casn), .sdram_wen(sdram_wen), .sdram_a(sdram_a),
      .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_d(sdram_d)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_le(input string nm, input int act, input int lim);
      vectors++;
      if (act > lim) begin
         miscompares++;
         $display("FAIL %s: got %0d, limit %0d", nm, act, lim);
      end
   endtask

   // behavioural SDRAM: command log, timing rules, storage and CL-delayed read drive
   typedef struct {int c; logic [3:0] cmd; logic [12:0] a;} ev_t;
   ev_t         log_q[$];
   int          rd_cyc_q[$];
   logic [15:0] mem[int];
   logic [3:0]  pc, prev_cmd = C_NOP;
   logic [1:0]  act_bank = '0;
   logic [12:0] act_row = '0;
   logic [15:0] v;
   int rd_cnt = -1, last_c = -1, need = 0, ref_c = -1, max_ref_gap = 0, n_ref = 0, cke_c = -1, done_c = -1, k;
   always @(negedge clk_sys) begin
      pc = {sdram_csn, sdram_rasn, sdram_casn, sdram_wen};
      if (m_oe) m_oe = 1'b0;
      if (rd_cnt > 0) rd_cnt--;
      else if (rd_cnt == 0) begin m_oe = 1'b1; rd_cnt = -1; end
      if (rst) begin
         log_q.delete(); rd_cyc_q.delete();
         cke_c = -1; done_c = -1; last_c = -1; ref_c = -1; rd_cnt = -1; m_oe = 1'b0;
      end else begin
         if (sdram_cke && cke_c < 0) cke_c = cyc;
         if (init_done && done_c < 0) done_c = cyc;
         if (pc != C_NOP) begin
            log_q.push_back('{cyc, pc, sdram_a});
            if (last_c >= 0) begin
               vectors++;
               if (cyc - last_c < need) begin
                  miscompares++;
                  $display("FAIL cmd_gap: cmd %b %0d cycles after %b, need %0d", pc, cyc - last_c, prev_cmd, need);
               end
            end
            if (pc == C_ACT) begin act_bank = sdram_ba; act_row = sdram_a; end
            if (pc == C_RD || pc == C_WR) begin
               chk("rw_prev_cmd", prev_cmd, C_ACT);
               chk("rw_bank", sdram_ba, act_bank);
               chk("rw_autoprecharge", sdram_a[10], 1);
               k = int'({act_bank, act_row, sdram_a[8:0]});
               v = mem.exists(k) ? mem[k] : 16'h0;
               if (pc == C_WR) begin
                  if (!sdram_dqm[0]) v[7:0] = sdram_d[7:0];
                  if (!sdram_dqm[1]) v[15:8] = sdram_d[15:8];
                  mem[k] = v;
               end else begin
                  chk("rd_dqm", sdram_dqm, 2'b00);
                  m_d = v;
                  rd_cnt = CL - 1;
                  rd_cyc_q.push_back(cyc);
               end
            end
            if (pc == C_REF && init_done) begin
               chk("ready_during_ref", req_ready, 0);
               if (ref_c >= 0 && cyc - ref_c > max_ref_gap) max_ref_gap = cyc - ref_c;
               ref_c = cyc;
               n_ref++;
            end
            need = pc == C_PRE ? T_RP : pc == C_REF ? T_RFC : pc == C_MRS ? T_MRD :
                   pc == C_ACT ? T_RCD : pc == C_WR ? T_WR + T_RP : pc == C_RD ? T_RP + 1 : 1;
            prev_cmd = pc;
            last_c = cyc;
         end
      end
   end

   // scoreboard monitor
   logic [15:0] exp_q[$];
   always @(negedge clk_sys)
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding, data %h", rsp_rdata);
         end else begin
            chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
            if (rd_cyc_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL rsp_latency: response without an RD on the pins");
            end else chk("rsp_latency", cyc - rd_cyc_q.pop_front(), LAT);
         end
      end

   // word-level reference memory
   logic [15:0] ref_mem[int];
   task automatic do_req(input logic we, input logic [23:0] addr, input logic [15:0] d, input logic [1:0] m);
      int t = 0;
      logic [15:0] r;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d; req_wmask = m;
      while (!req_ready && t < 1000) begin @(negedge clk_sys); t++; end
      if (!req_ready) begin
         vectors++; miscompares++;
         $display("FAIL req_timeout: request %h not accepted in %0d cycles", addr, t);
      end else begin
         r = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0;
         if (we) ref_mem[int'(addr)] = {m[1] ? d[15:8] : r[15:8], m[0] ? d[7:0] : r[7:0]};
         else exp_q.push_back(r);
      end
      @(negedge clk_sys);
      req_valid = 1'b0;
   endtask

   task automatic check_init();
      int t = 0;
      while (!init_done && t < T_INIT + 200) begin @(negedge clk_sys); t++; end
      @(negedge clk_sys);
      chk("init_done", init_done, 1);
      if (log_q.size() >= 4) begin
         chk("init_nop_cycles", log_q[0].c - cke_c, T_INIT);
         chk("init_cmd_pre", log_q[0].cmd, C_PRE);
         chk("init_pre_all", log_q[0].a[10], 1);
         chk("init_cmd_ref1", log_q[1].cmd, C_REF);
         chk("init_cmd_ref2", log_q[2].cmd, C_REF);
         chk("init_cmd_mrs", log_q[3].cmd, C_MRS);
         chk("init_mrs_a", log_q[3].a, 13'h0220);
         chk("init_done_delay", done_c - log_q[3].c, T_MRD);
      end else begin
         vectors++; miscompares++;
         $display("FAIL init_seq: only %0d commands seen", log_q.size());
      end
   endtask

   task automatic check_reset_pins(input string tag);
      chk({tag, "_cke"}, sdram_cke, 0);
      chk({tag, "_cmd"}, {sdram_csn, sdram_rasn, sdram_casn, sdram_wen}, C_NOP);
      chk({tag, "_a"}, sdram_a, 0);
      chk({tag, "_ba"}, sdram_ba, 0);
      chk({tag, "_dqm"}, sdram_dqm, 2'b11);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_init_done"}, init_done, 0);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin @(negedge clk_sys); t++; end
      chk("outstanding_reads", exp_q.size(), 0);
   endtask

   logic [23:0] pool[8] = '{24'h3FFE01, 24'h000000, 24'hFFFFFF, 24'h400000,
                            24'h0001FF, 24'h800200, 24'hC00000, 24'h7FFE00};

   initial begin
      int t0;
      repeat (3) @(negedge clk_sys);
      check_reset_pins("reset");
      rst = 1'b0;
      check_init();
      do_req(1'b1, 24'h3FFE01, 16'hA5C3, 2'b11);
      do_req(1'b0, 24'h3FFE01, 16'h0, 2'b00);
      do_req(1'b1, 24'h000000, 16'hFFFF, 2'b11);
      do_req(1'b1, 24'h000000, 16'h1234, 2'b01);
      do_req(1'b0, 24'h000000, 16'h0, 2'b00);
      do_req(1'b1, 24'hFFFFFF, 16'h8001, 2'b10);
      do_req(1'b0, 24'hFFFFFF, 16'h0, 2'b00);
      t0 = cyc;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 3) repeat ($urandom_range(1, 4)) @(negedge clk_sys);
         do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom), 2'($urandom_range(0, 3)));
      end
      drain();
      chk_le("refresh_max_gap", max_ref_gap, T_REFI + 10);
      chk_le("refresh_too_few", (cyc - t0) / T_REFI - 1, n_ref);
      do_req(1'b0, 24'h3FFE01, 16'h0, 2'b00);
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_reset_pins("midread_rst");
      repeat (3) @(negedge clk_sys);
      rst = 1'b0;
      check_init();
      do_req(1'b0, 24'h3FFE01, 16'h0, 2'b00);
      do_req(1'b0, 24'h000000, 16'h0, 2'b00);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
